// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: minuend - subtrahend, one bit per debounced button
// press, LSB first. Switches and the step button are active-low and pass
// through 2-flop synchronizers; LEDs are active-low.
// Optional feature macro: SERIAL_SUB_DEBOUNCE_EN compiles in the step-button
// debounce counter. When undefined the synchronized button level is used as-is.
module serial_subtractor #(
  parameter int WIDTH           = 4,
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             s1,
  input  logic             s2,
  input  logic             step_n,
  output logic [WIDTH+1:0] led
);

  localparam int CW = $clog2(WIDTH + 1);

  if (WIDTH < 2 || WIDTH > 16 || DEBOUNCE_CYCLES < 1) begin : g_param_check
    $error("serial_subtractor: WIDTH must be 2..16 and DEBOUNCE_CYCLES >= 1");
  end

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  logic [1:0] s1_sync_q, s1_sync_d;
  logic [1:0] s2_sync_q, s2_sync_d;
  logic [1:0] step_sync_q, step_sync_d;
  logic       db;
  logic       db_prev_q, db_prev_d;
  logic       press;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             borrow_q, borrow_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             a, b, d, borrow_next;

  // Synchronizer shift stages and previous debounced level for edge detect
  always_comb begin
    s1_sync_d   = {s1_sync_q[0], s1};
    s2_sync_d   = {s2_sync_q[0], s2};
    step_sync_d = {step_sync_q[0], step_n};
    db_prev_d   = db;
  end

  // Synchronizer and edge-detect registers; released (1) out of reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_sync_q   <= '1;
      s2_sync_q   <= '1;
      step_sync_q <= '1;
      db_prev_q   <= 1'b1;
    end else begin
      s1_sync_q   <= s1_sync_d;
      s2_sync_q   <= s2_sync_d;
      step_sync_q <= step_sync_d;
      db_prev_q   <= db_prev_d;
    end
  end

`ifdef SERIAL_SUB_DEBOUNCE_EN
  localparam int DBW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

  logic           db_q, db_d;
  logic [DBW-1:0] db_cnt_q, db_cnt_d;

  // Accept a new button level only after it has differed for DEBOUNCE_CYCLES
  always_comb begin
    db_d     = db_q;
    db_cnt_d = '0;
    if (step_sync_q[1] != db_q) begin
      if (db_cnt_q == DBW'(DEBOUNCE_CYCLES - 1)) begin
        db_d = step_sync_q[1];
      end else begin
        db_cnt_d = db_cnt_q + 1'b1;
      end
    end
  end

  // Debounced level and stability counter
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      db_q     <= 1'b1;
      db_cnt_q <= '0;
    end else begin
      db_q     <= db_d;
      db_cnt_q <= db_cnt_d;
    end
  end

  assign db = db_q;
`else
  assign db = step_sync_q[1];
`endif

  // Press is the 1 -> 0 transition of the debounced level
  assign press = db_prev_q & ~db;

  // Serial full-subtractor cell on the synchronized switch levels
  always_comb begin
    a           = ~s1_sync_q[1];
    b           = ~s2_sync_q[1];
    d           = a ^ b ^ borrow_q;
    borrow_next = (~a & b) | (~a & borrow_q) | (b & borrow_q);
  end

  // Next state and datapath update: capture in IDLE/RUN, clear out of DONE
  always_comb begin
    state_d  = state_q;
    diff_d   = diff_q;
    borrow_d = borrow_q;
    cnt_d    = cnt_q;
    unique case (state_q)
      IDLE, RUN: begin
        if (press) begin
          diff_d   = {d, diff_q[WIDTH-1:1]};
          borrow_d = borrow_next;
          cnt_d    = cnt_q + 1'b1;
          state_d  = (cnt_q == CW'(WIDTH - 1)) ? DONE : RUN;
        end
      end
      DONE: begin
        if (press) begin
          diff_d   = '0;
          borrow_d = 1'b0;
          cnt_d    = '0;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      diff_q   <= '0;
      borrow_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      diff_q   <= diff_d;
      borrow_q <= borrow_d;
      cnt_q    <= cnt_d;
    end
  end

  assign led = {~(state_q == DONE), ~borrow_q, ~diff_q};

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed self-checking bench for serial_subtractor (WIDTH=4, DEBOUNCE_CYCLES=4).
module tb_serial_subtractor;

  localparam int W  = 4;
  localparam int DC = 4;
`ifdef SERIAL_SUB_DEBOUNCE_EN
  localparam int LAT = 3 + DC;
`else
  localparam int LAT = 3;
`endif

  logic         clk;
  logic         rst_n;
  logic         s1;
  logic         s2;
  logic         step_n;
  logic [W+1:0] led;

  int checks;
  int errors;

  serial_subtractor #(
    .WIDTH          (W),
    .DEBOUNCE_CYCLES(DC)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .s1    (s1),
    .s2    (s2),
    .step_n(step_n),
    .led   (led)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [W+1:0] exp);
    checks++;
    assert (led === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, led, exp);
    end
  endtask

  task automatic do_reset();
    rst_n  = 1'b0;
    step_n = 1'b1;
    s1     = 1'b1;
    s2     = 1'b1;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
  endtask

  // a/b are the logical operand bits; switches are active-low
  task automatic press(input logic a, input logic b);
    s1     = ~a;
    s2     = ~b;
    step_n = 1'b0;
    repeat (10) tick();
    step_n = 1'b1;
    repeat (10) tick();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    step_n = 1'b1;
    s1     = 1'b1;
    s2     = 1'b1;
    repeat (2) tick();
    check("reset_hold", 6'b111111);
    rst_n = 1'b1;
    tick();
    check("reset", 6'b111111);

    // Exact latency and held-button single press, bit (a,b)=(1,0)
    s1     = 1'b0;
    s2     = 1'b1;
    step_n = 1'b0;
    repeat (LAT - 1) tick();
    check("lat_before", 6'b111111);
    tick();
    check("lat_after", 6'b110111);
    repeat (20) tick();
    check("held_once", 6'b110111);
    step_n = 1'b1;
    repeat (10) tick();
    check("release_none", 6'b110111);

    // 5 - 3
    do_reset();
    check("reset2", 6'b111111);
    press(1'b1, 1'b1);
    check("sub53_b0", 6'b111111);
    press(1'b0, 1'b1);
    check("sub53_b1", 6'b100111);
    press(1'b1, 1'b0);
    check("sub53_b2", 6'b111011);
    press(1'b0, 1'b0);
    check("sub53_done", 6'b011101);
    press(1'b1, 1'b0);
    check("sub53_clear", 6'b111111);

    // 3 - 5
    press(1'b1, 1'b1);
    check("sub35_b0", 6'b111111);
    press(1'b1, 1'b0);
    check("sub35_b1", 6'b110111);
    press(1'b0, 1'b1);
    check("sub35_b2", 6'b100011);
    press(1'b0, 1'b0);
    check("sub35_done", 6'b000001);
    press(1'b1, 1'b0);
    check("sub35_clear", 6'b111111);

`ifdef SERIAL_SUB_DEBOUNCE_EN
    // Bounce shorter than the debounce window yields one press
    s1 = 1'b0;
    s2 = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step_n = (i % 2 == 0) ? 1'b0 : 1'b1;
      repeat (2) tick();
    end
    check("bounce_none", 6'b111111);
    step_n = 1'b0;
    repeat (15) tick();
    check("bounce_one", 6'b110111);
    step_n = 1'b1;
    repeat (10) tick();
    press(1'b1, 1'b0);
    check("bounce_next", 6'b110011);
`endif

    // Reset coinciding with the capture edge of the third press
    do_reset();
    press(1'b1, 1'b1);
    press(1'b0, 1'b1);
    check("midop_pre", 6'b100111);
    s1     = 1'b0;
    s2     = 1'b1;
    step_n = 1'b0;
    repeat (LAT - 1) tick();
    rst_n = 1'b0;
    tick();
    check("midop_rst", 6'b111111);
    step_n = 1'b1;
    tick();
    rst_n = 1'b1;
    repeat (10) tick();
    check("midop_idle", 6'b111111);
    press(1'b1, 1'b0);
    check("midop_bit0", 6'b110111);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
